// File: rtl/top_module_byte_split.sv
// Splits a 16-bit halfword into high and low bytes with zero latency, and keeps
// registered copies of both bytes plus an input-change counter for status/debug.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst_n    - asynchronous active-low reset
//   in       - halfword to split
//   out_hi   - in[15:8], combinational
//   out_lo   - in[7:0], combinational
//   par_hi   - XOR-reduce of in[15:8], combinational (1 = odd number of ones)
//   par_lo   - XOR-reduce of in[7:0], combinational
//   out_hi_q - in[15:8] registered
//   out_lo_q - in[7:0] registered
//   valid_q  - registered bytes hold a sample taken after reset release
//   chg_cnt  - rising edges at which in differed from the last captured value
module top_module_byte_split #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      in,
  output logic [7:0]       out_hi,
  output logic [7:0]       out_lo,
  output logic             par_hi,
  output logic             par_lo,
  output logic [7:0]       out_hi_q,
  output logic [7:0]       out_lo_q,
  output logic             valid_q,
  output logic [CNT_W-1:0] chg_cnt
);

  logic [7:0]       out_hi_d;
  logic [7:0]       out_lo_d;
  logic             valid_d;
  logic [CNT_W-1:0] chg_cnt_q;
  logic [CNT_W-1:0] chg_cnt_d;
  logic             changed;

  // Split path is purely wired and never gated by reset or clock.
  assign out_hi = in[15:8];
  assign out_lo = in[7:0];
  assign par_hi = ^in[15:8];
  assign par_lo = ^in[7:0];

  always_comb begin
    out_hi_d  = in[15:8];
    out_lo_d  = in[7:0];
    valid_d   = 1'b1;
    // The first capture after reset has nothing to compare against.
    changed   = valid_q && (in != {out_hi_q, out_lo_q});
    chg_cnt_d = chg_cnt_q;
    if (changed) begin
      chg_cnt_d = chg_cnt_q + CNT_W'(1);  // wraps naturally modulo 2^CNT_W
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_hi_q  <= 8'h00;
      out_lo_q  <= 8'h00;
      valid_q   <= 1'b0;
      chg_cnt_q <= '0;
    end else begin
      out_hi_q  <= out_hi_d;
      out_lo_q  <= out_lo_d;
      valid_q   <= valid_d;
      chg_cnt_q <= chg_cnt_d;
    end
  end

  assign chg_cnt = chg_cnt_q;

endmodule

// File: tb/tb_top_module_byte_split.sv
module tb_top_module_byte_split;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in = 16'h0000;

  logic [7:0]  out_hi, out_lo, out_hi_q, out_lo_q;
  logic        par_hi, par_lo, valid_q;
  logic [15:0] chg_cnt;

  logic [7:0]  w_out_hi, w_out_lo, w_out_hi_q, w_out_lo_q;
  logic        w_par_hi, w_par_lo, w_valid_q;
  logic [1:0]  w_chg_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: last captured halfword, capture flag, unbounded change count.
  logic [15:0] m_prev  = 16'h0000;
  logic        m_valid = 1'b0;
  logic [31:0] m_cnt   = 32'd0;

  always #5 clk = ~clk;

  top_module_byte_split dut (
    .clk(clk), .rst_n(rst_n), .in(in),
    .out_hi(out_hi), .out_lo(out_lo), .par_hi(par_hi), .par_lo(par_lo),
    .out_hi_q(out_hi_q), .out_lo_q(out_lo_q), .valid_q(valid_q), .chg_cnt(chg_cnt)
  );

  top_module_byte_split #(.CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .in(in),
    .out_hi(w_out_hi), .out_lo(w_out_lo), .par_hi(w_par_hi), .par_lo(w_par_lo),
    .out_hi_q(w_out_hi_q), .out_lo_q(w_out_lo_q), .valid_q(w_valid_q), .chg_cnt(w_chg_cnt)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev  = 16'h0000;
      m_valid = 1'b0;
      m_cnt   = 32'd0;
    end else begin
      if (m_valid && (in != m_prev)) m_cnt = m_cnt + 1;
      m_prev  = in;
      m_valid = 1'b1;
    end
  end

  function automatic logic odd_ones(input logic [7:0] b);
    return logic'($countones(b) % 2);
  endfunction

  task automatic test_comb;
    in = 16'hA55A;
    #1;
    n_checks++;
    if ({out_hi, out_lo} !== 16'hA55A || out_hi !== 8'hA5 || out_lo !== 8'h5A) begin
      n_fail++;
      $display("FAIL comb_split: got %h_%h want a5_5a", out_hi, out_lo);
    end
    n_checks++;
    if (par_hi !== 1'b0 || par_lo !== 1'b0) begin
      n_fail++;
      $display("FAIL comb_parity: got %b%b want 00", par_hi, par_lo);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in = 16'h8001;
    #1;
    n_checks++;
    if (out_hi !== 8'h80 || out_lo !== 8'h01 || par_hi !== 1'b1 || par_lo !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_comb: got %h %h %b %b want 80 01 1 1", out_hi, out_lo, par_hi, par_lo);
    end
    n_checks++;
    if (out_hi_q !== 8'h00 || out_lo_q !== 8'h00 || valid_q !== 1'b0 || chg_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h %h %b %h want 00 00 0 0000",
               out_hi_q, out_lo_q, valid_q, chg_cnt);
    end
  endtask

  task automatic test_release;
    @(negedge clk);
    in = 16'h1234;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_hi_q !== 8'h12 || out_lo_q !== 8'h34 || valid_q !== 1'b1 || chg_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL first_capture: got %h %h %b %h want 12 34 1 0000",
               out_hi_q, out_lo_q, valid_q, chg_cnt);
    end
  endtask

  task automatic test_sequence;
    logic [15:0] seq [4];
    logic [15:0] exp [4];
    seq[0] = 16'h1234; seq[1] = 16'h1234; seq[2] = 16'hFFFF; seq[3] = 16'h0000;
    exp[0] = 16'd0;    exp[1] = 16'd0;    exp[2] = 16'd1;    exp[3] = 16'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in = seq[i];
      @(posedge clk);
      #1;
      n_checks++;
      if (chg_cnt !== exp[i] || chg_cnt !== m_cnt[15:0]) begin
        n_fail++;
        $display("FAIL seq_cnt[%0d]: got %0d want %0d", i, chg_cnt, exp[i]);
      end
      n_checks++;
      if ({out_hi_q, out_lo_q} !== seq[i]) begin
        n_fail++;
        $display("FAIL seq_regs[%0d]: got %h want %h", i, {out_hi_q, out_lo_q}, seq[i]);
      end
    end
  endtask

  task automatic test_random_both_edges;
    int bad_split = 0;
    int bad_regs = 0;
    for (int e = 0; e < 220; e++) begin
      if (e % 2 == 0) @(posedge clk); else @(negedge clk);
      #1;
      // Registered state after this edge must match the model.
      if ({out_hi_q, out_lo_q} !== m_prev || chg_cnt !== m_cnt[15:0] ||
          w_chg_cnt !== m_cnt[1:0] || valid_q !== 1'b1) begin
        bad_regs++;
        if (bad_regs <= 4)
          $display("FAIL rand_regs[%0d]: got %h cnt %0d/%0d want %h cnt %0d", e,
                   {out_hi_q, out_lo_q}, chg_cnt, w_chg_cnt, m_prev, m_cnt[15:0]);
      end
      // Bias toward repeats so the counter sees both outcomes.
      if ($urandom_range(3) != 0) in = 16'($urandom);
      #1;
      if (out_hi !== in[15:8] || out_lo !== in[7:0] ||
          par_hi !== odd_ones(in[15:8]) || par_lo !== odd_ones(in[7:0])) begin
        bad_split++;
        if (bad_split <= 4)
          $display("FAIL rand_split[%0d]: got %h%h p%b%b in %h", e, out_hi, out_lo,
                   par_hi, par_lo, in);
      end
    end
    n_checks++;
    if (bad_split != 0) begin
      n_fail++;
      $display("FAIL rand_split_total: got %0d mismatches want 0", bad_split);
    end
    n_checks++;
    if (bad_regs != 0) begin
      n_fail++;
      $display("FAIL rand_regs_total: got %0d mismatches want 0", bad_regs);
    end
  endtask

  task automatic test_wrap_and_midreset;
    logic [1:0] exp_w [4];
    exp_w[0] = 2'd1; exp_w[1] = 2'd2; exp_w[2] = 2'd3; exp_w[3] = 2'd0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    in = 16'h0000;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in = 16'(i + 1);
      @(posedge clk);
      #1;
      n_checks++;
      if (w_chg_cnt !== exp_w[i] || w_chg_cnt !== m_cnt[1:0] || chg_cnt !== 16'(i + 1)) begin
        n_fail++;
        $display("FAIL wrap_cnt[%0d]: got %0d/%0d want %0d/%0d", i, w_chg_cnt, chg_cnt,
                 exp_w[i], i + 1);
      end
    end
    @(negedge clk);
    in = 16'hBEEF;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_hi_q !== 8'h00 || out_lo_q !== 8'h00 || valid_q !== 1'b0 || chg_cnt !== 16'h0 ||
        w_out_hi_q !== 8'h00 || w_out_lo_q !== 8'h00 || w_valid_q !== 1'b0 ||
        w_chg_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL midreset_regs: got %h %h %b %h / %h %h %b %h want all zero",
               out_hi_q, out_lo_q, valid_q, chg_cnt, w_out_hi_q, w_out_lo_q, w_valid_q,
               w_chg_cnt);
    end
    n_checks++;
    if (out_hi !== 8'hBE || out_lo !== 8'hEF || w_out_hi !== 8'hBE || w_out_lo !== 8'hEF) begin
      n_fail++;
      $display("FAIL midreset_comb: got %h%h / %h%h want beef", out_hi, out_lo,
               w_out_hi, w_out_lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (valid_q !== 1'b1 || chg_cnt !== 16'h0 || {out_hi_q, out_lo_q} !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL post_reset_capture: got %b %h %h want 1 0000 beef", valid_q, chg_cnt,
               {out_hi_q, out_lo_q});
    end
  endtask

  initial begin
    test_comb();
    test_reset();
    test_release();
    test_sequence();
    test_random_both_edges();
    test_wrap_and_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
